memdata_arbiter: RTL
====================

// Module: memdata_arbiter
// PURPOSE
//  Shares the single-port data memory (9-bit address, 16-bit word, async read,
//  write on posedge clk) between the pipeline MEM stage (CPU port) and a
//  DMA/debug master (DMA port). The CPU has fixed priority; a starvation
//  counter forces a one-cycle DMA slot, stalling the CPU. Sits between the
//  MEM stage / DMA engine and the data memory instance.
// PARAMETERS
//  ADDR_W        9   address width (matches data memory)
//  DATA_W        16  data word width
//  STARVE_LIMIT  8   consecutive denied DMA cycles before a forced DMA slot (>=1)
// PORTS
//  clk           in   1       system clock, all state on posedge
//  rst_n         in   1       asynchronous active-low reset
//  cpu_req       in   1       MEM stage accesses memory this cycle
//  cpu_we        in   1       1 = write, 0 = read
//  cpu_address   in   ADDR_W  CPU word address
//  cpu_wdata     in   DATA_W  CPU write data
//  cpu_rdata     out  DATA_W  CPU read data (combinational from memory)
//  cpu_stall     out  1       CPU access not performed this cycle; hold pipeline
//  dma_req       in   1       DMA requests access; hold fields stable until dma_gnt
//  dma_we        in   1       1 = write, 0 = read
//  dma_address   in   ADDR_W  DMA word address
//  dma_wdata     in   DATA_W  DMA write data
//  dma_gnt       out  1       DMA access performed this cycle
//  dma_rdata     out  DATA_W  registered DMA read data
//  dma_rvalid    out  1       dma_rdata valid, one-cycle pulse
//  mem_we        out  1       to memory write enable
//  mem_address   out  ADDR_W  to memory address
//  mem_data_in   out  DATA_W  to memory write data
//  mem_data_out  in   DATA_W  from memory async read data
// BEHAVIOUR
//  - States: NORMAL, FORCE. Counter wait_cnt, range 0..STARVE_LIMIT-1.
//  - Reset (rst_n low, async): state=NORMAL, wait_cnt=0, dma_rdata=0,
//    dma_rvalid=0; while low dma_gnt=0, cpu_stall=0, mem_we=0 (combinational gate).
//  - NORMAL grant: cpu_req ? CPU : (dma_req ? DMA : none). cpu_stall=0.
//  - FORCE grant: dma_req ? DMA (cpu_stall=cpu_req) : CPU as NORMAL (cpu_stall=0).
//  - Grant decided combinationally in the same cycle; zero-latency for winner.
//  - Memory mux: mem_address/mem_data_in from granted port; CPU when none
//    granted. mem_we = granted port's we (cpu_req&cpu_we or dma_we); 0 if none.
//  - cpu_rdata = mem_data_out always; valid only when cpu_req & !cpu_stall.
//  - DMA read: posedge with dma_gnt & !dma_we -> dma_rdata<=mem_data_out,
//    dma_rvalid<=1 for exactly one cycle; otherwise dma_rvalid<=0, dma_rdata holds.
//  - wait_cnt: cleared when dma_gnt or !dma_req; else increments each denied cycle.
//  - NORMAL->FORCE when dma_req & !dma_gnt & wait_cnt==STARVE_LIMIT-1:
//    DMA denied exactly STARVE_LIMIT cycles, granted in cycle STARVE_LIMIT+1.
//  - FORCE lasts one cycle, always returns to NORMAL with wait_cnt=0; CPU then
//    owns at least STARVE_LIMIT cycles before next forced slot.
//  - dma_req dropped in FORCE: no DMA grant, no stall, return NORMAL.
//  - STARVE_LIMIT=1: DMA never waits more than one cycle behind CPU.
//  - Reset asserted in any cycle: the in-flight write is not committed.
// TESTING
//  1 rst_n=0, cpu_req=1 cpu_we=1 -> mem_we=0, cpu_stall=0, dma_rvalid=0, dma_rdata=0.
//  2 CPU write 0x012<-0xBEEF, next cycle read 0x012 -> cpu_rdata=0xBEEF, stall 0.
//  3 DMA-only read 0x1FF (preloaded 0x1234) -> dma_gnt same cycle; next cycle
//    dma_rdata=0x1234, dma_rvalid=1 for one cycle.
//  4 cpu_req held 1, dma write 0x005<-0xA5A5 held -> dma_gnt=0 for 8 cycles;
//    cycle 9 dma_gnt=1, cpu_stall=1, mem_we=1 @0x005; cycle 10 stall=0, wait restarts.
//  5 As 4 but dma_req drops in FORCE cycle -> dma_gnt=0, cpu_stall=0, NORMAL next.
//  6 rst_n pulsed low during FORCE cycle -> mem_we=0 immediately, 0x005 unchanged,
//    state NORMAL, wait_cnt=0 after release.

Source files
------------

// File: rtl/memdata_arbiter.sv
// Data-memory arbiter: the CPU MEM stage has fixed priority over a DMA/debug
// master, and a starvation counter forces a one-cycle DMA slot.
module memdata_arbiter #(
  parameter int ADDR_W       = 9,
  parameter int DATA_W       = 16,
  parameter int STARVE_LIMIT = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_address,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_stall,
  input  logic              dma_req,
  input  logic              dma_we,
  input  logic [ADDR_W-1:0] dma_address,
  input  logic [DATA_W-1:0] dma_wdata,
  output logic              dma_gnt,
  output logic [DATA_W-1:0] dma_rdata,
  output logic              dma_rvalid,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_data_in,
  input  logic [DATA_W-1:0] mem_data_out
);

  localparam int CNT_W = (STARVE_LIMIT > 1) ? $clog2(STARVE_LIMIT) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT - 1);

  typedef enum logic {NORMAL, FORCE} state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  wait_cnt_q, wait_cnt_d;
  logic [DATA_W-1:0] dma_rdata_q, dma_rdata_d;
  logic              dma_rvalid_q, dma_rvalid_d;
  logic              dma_win;

  // Grant is gated by rst_n so nothing reaches the memory while reset is held.
  always_comb begin
    dma_win     = rst_n && dma_req && ((state_q == FORCE) || !cpu_req);
    dma_gnt     = dma_win;
    cpu_stall   = rst_n && cpu_req && dma_win;
    mem_we      = rst_n && (dma_win ? dma_we : (cpu_req && cpu_we));
    mem_address = dma_win ? dma_address : cpu_address;
    mem_data_in = dma_win ? dma_wdata : cpu_wdata;
    cpu_rdata   = mem_data_out;
  end

  always_comb begin
    state_d      = NORMAL;
    wait_cnt_d   = '0;
    dma_rvalid_d = dma_win && !dma_we;
    dma_rdata_d  = dma_rvalid_d ? mem_data_out : dma_rdata_q;
    if ((state_q == NORMAL) && dma_req && !dma_win) begin
      if (wait_cnt_q == CNT_MAX) begin
        state_d = FORCE;
      end else begin
        wait_cnt_d = wait_cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= NORMAL;
      wait_cnt_q   <= '0;
      dma_rdata_q  <= '0;
      dma_rvalid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      wait_cnt_q   <= wait_cnt_d;
      dma_rdata_q  <= dma_rdata_d;
      dma_rvalid_q <= dma_rvalid_d;
    end
  end

  assign dma_rdata  = dma_rdata_q;
  assign dma_rvalid = dma_rvalid_q;

endmodule
